// File: rtl/hamming_frame_accum.sv
// Per-frame Hamming-weight accumulator: sums the popcount of FRAME_LEN accepted
// words and tracks the largest single-word weight, presenting both via valid/ready.
module hamming_frame_accum #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [4:0]       out_max,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  generate
    if (FRAME_LEN < 1 || FRAME_LEN > 256) begin : g_bad_frame_len
      $error("hamming_frame_accum: FRAME_LEN must be in 1..256");
    end
    if (SUM_W < 31 && (1 << SUM_W) <= 16 * FRAME_LEN) begin : g_bad_sum_w
      $error("hamming_frame_accum: SUM_W too narrow, need 2**SUM_W > 16*FRAME_LEN");
    end
  endgenerate

  function automatic logic [4:0] popcount16(input logic [15:0] w);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(w[i]);
    return c;
  endfunction

  function automatic logic [4:0] umax5(input logic [4:0] a, input logic [4:0] b);
    return (b > a) ? b : a;
  endfunction

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [4:0]       mx_q, mx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [4:0]       out_max_q, out_max_d;
  logic             out_valid_q, out_valid_d;

  logic [4:0]       pc;
  logic             in_xfer;
  logic             out_xfer;

  assign pc       = popcount16(in_data);
  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    acc_d       = acc_q;
    mx_d        = mx_q;
    idx_d       = idx_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_valid_d = out_valid_q;

    if (out_xfer) out_valid_d = 1'b0;

    // clear wins over any word transferred in the same cycle, final or not
    if (clear) begin
      acc_d = '0;
      mx_d  = '0;
      idx_d = '0;
    end else if (in_xfer) begin
      if (idx_q == LAST_IDX) begin
        out_sum_d   = acc_q + SUM_W'(pc);
        out_max_d   = umax5(mx_q, pc);
        out_valid_d = 1'b1;
        acc_d       = '0;
        mx_d        = '0;
        idx_d       = '0;
      end else begin
        acc_d = acc_q + SUM_W'(pc);
        mx_d  = umax5(mx_q, pc);
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      mx_q        <= '0;
      idx_q       <= '0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mx_q        <= mx_d;
      idx_q       <= idx_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hamming_frame_accum.sv
// Directed bench for hamming_frame_accum: a FRAME_LEN=4 instance for the handshake
// scenarios and a FRAME_LEN=1 instance for the exhaustive popcount sweep.
module tb_hamming_frame_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  out_sum;
  logic [4:0]  out_max;
  logic        out_valid;
  logic        out_ready;

  logic        clear_b;
  logic [15:0] in_data_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic [4:0]  out_sum_b;
  logic [4:0]  out_max_b;
  logic        out_valid_b;
  logic        out_ready_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_frame_accum #(.FRAME_LEN(4), .SUM_W(7)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sum(out_sum), .out_max(out_max), .out_valid(out_valid), .out_ready(out_ready)
  );

  hamming_frame_accum #(.FRAME_LEN(1), .SUM_W(5)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_sum(out_sum_b), .out_max(out_max_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    chk("send_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int results;
    logic [4:0] ref_pc;

    reset = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    clear_b = 1'b0; in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // 1: basic frame, weights 0+16+4+2
    send(16'h0000);
    send(16'hFFFF);
    send(16'h000F);
    send(16'h8001);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_sum", 32'(out_sum), 22);
    chk("t1_max", 32'(out_max), 16);

    // 2: backpressure holds result and blocks input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    #1;
    chk("t2_in_ready_stall", 32'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(out_valid), 1);
      chk("t2_hold_sum", 32'(out_sum), 22);
      chk("t2_hold_max", 32'(out_max), 16);
      chk("t2_in_ready_stall", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready_release", 32'(in_ready), 1);
    tick();
    chk("t2_consumed", 32'(out_valid), 0);

    // 3: 12 x FFFF continuous, results every 4th cycle
    results  = 0;
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      chk("t3_in_ready", 32'(in_ready), 1);
      tick();
      chk("t3_valid_pattern", 32'(out_valid), (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) begin
        results++;
        chk("t3_sum", 32'(out_sum), 64);
        chk("t3_max", 32'(out_max), 16);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t3_drained", 32'(out_valid), 0);
    chk("t3_result_count", 32'(results), 3);

    // 4: clear discards partial frame and the word in the clear cycle
    send(16'h0007);
    send(16'h0003);
    clear = 1'b1;
    send(16'hFFFF);
    clear = 1'b0;
    send(16'h0001);
    send(16'h0001);
    send(16'h0001);
    chk("t4_no_early", 32'(out_valid), 0);
    send(16'h0001);
    chk("t4_valid", 32'(out_valid), 1);
    chk("t4_sum", 32'(out_sum), 4);
    chk("t4_max", 32'(out_max), 1);
    tick();
    chk("t4_drained", 32'(out_valid), 0);

    // clear on a would-be final word produces no result and keeps the old register
    send(16'h0003);
    send(16'h0003);
    send(16'h0003);
    clear = 1'b1;
    send(16'h0003);
    clear = 1'b0;
    chk("t4b_no_result", 32'(out_valid), 0);
    chk("t4b_reg_kept", 32'(out_sum), 4);
    send(16'h0003);
    send(16'h0003);
    send(16'h0003);
    send(16'h00FF);
    chk("t4b_sum", 32'(out_sum), 14);
    chk("t4b_max", 32'(out_max), 8);

    // 6: reset with a result pending, then reset after a partial frame
    out_ready = 1'b0;
    tick();
    chk("t6_pending", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_sum", 32'(out_sum), 0);
    chk("t6_rst_max", 32'(out_max), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    send(16'hFFFF);
    send(16'hFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(16'h0001);
    send(16'h0003);
    send(16'h0007);
    send(16'h000F);
    chk("t6_fresh_valid", 32'(out_valid), 1);
    chk("t6_fresh_sum", 32'(out_sum), 10);
    chk("t6_fresh_max", 32'(out_max), 4);

    // 5: FRAME_LEN=1 exhaustive popcount sweep
    in_valid_b = 1'b1;
    for (int x = 0; x < 65536; x++) begin
      in_data_b = 16'(x);
      tick();
      ref_pc = '0;
      for (int b = 0; b < 16; b++) if (((x >> b) & 1) == 1) ref_pc = ref_pc + 5'd1;
      chk("t5_valid", 32'(out_valid_b), 1);
      chk("t5_sum", 32'(out_sum_b), 32'(ref_pc));
      chk("t5_max", 32'(out_max_b), 32'(ref_pc));
    end
    in_valid_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
